wb_uart_tx: RTL and testbench

WB_UART_TX -- requirements
Module: wb_uart_tx

---
 rtl/wb_uart_tx_pkg.sv | 38 +++
 rtl/wb_uart_tx_fifo.sv | 61 ++++++
 rtl/wb_uart_tx.sv | 191 +++++++++++++++++++
 tb/tb_wb_uart_tx.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// wb_uart_tx_pkg
// Shared definitions for the Wishbone UART transmitter: register offsets,
// STATUS bit positions and the transmit FSM state encoding.
// Optional feature macro: WB_UART_TX_PARITY_EN (adds the even-parity state).
// -----------------------------------------------------------------------------
package wb_uart_tx_pkg;

   // Register map (decoded on address bit 2 only)
   localparam logic [2:0] REG_TXDATA = 3'h0;
   localparam logic [2:0] REG_STATUS = 3'h4;

   // STATUS register bit positions
   localparam int STAT_FULL  = 0;
   localparam int STAT_EMPTY = 1;
   localparam int STAT_BUSY  = 2;
   localparam int STAT_OVF   = 3;

`ifdef WB_UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd3,
      ST_PARITY = 3'd4
   } tx_state_t;
`else
   localparam int FRAME_BITS = 10;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;
`endif

endpackage

// File: rtl/wb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// wb_uart_tx_fifo
// Synchronous 8-bit FIFO with first-word-fall-through read data.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_wdata   write strobe and byte (ignored when full)
//   i_pop             read strobe (ignored when empty)
//   o_full, o_empty   occupancy flags
//   o_rdata           head entry, valid whenever o_empty is low
// -----------------------------------------------------------------------------
module wb_uart_tx_fifo #(
   parameter int DEPTH = 16
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_push,
   input  logic [7:0] i_wdata,
   input  logic       i_pop,
   output logic       o_full,
   output logic       o_empty,
   output logic [7:0] o_rdata
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_rdata = r_mem[r_rptr];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   // Storage carries no reset; only pointers and count define contents.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr] <= i_wdata;
   end

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/wb_uart_tx.sv
// -----------------------------------------------------------------------------
// wb_uart_tx
// Wishbone classic slave feeding a FIFO-buffered UART transmitter (8N1, or
// 8E1 when WB_UART_TX_PARITY_EN is defined).
// Ports:
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   wb_adr_i[2:0]        byte address; bit 2 selects TXDATA (0x0) / STATUS (0x4)
//   wb_dat_i/wb_dat_o    32-bit write / read data (read data only while ack)
//   wb_we_i, wb_stb_i, wb_cyc_i, wb_sel_i   classic bus controls (sel[0] only)
//   wb_ack_o             single-cycle acknowledge
//   uart_tx              registered serial output, idle high
// STATUS: [0] FULL, [1] EMPTY, [2] BUSY, [3] OVF (sticky, write 1 to clear).
// -----------------------------------------------------------------------------
module wb_uart_tx
   import wb_uart_tx_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 10000000,
   parameter int BAUD        = 9600,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [2:0]  wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic        wb_we_i,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   input  logic [3:0]  wb_sel_i,
   output logic        wb_ack_o,
   output logic        uart_tx
);

   localparam int DIV = CLK_FREQ_HZ / BAUD;
   localparam int BW  = $clog2(DIV);

   // Bus side
   logic        r_ack;
   logic [31:0] r_dat_o;
   logic        r_ovf;
   logic        w_req;
   logic        w_wr;
   logic        w_wr_tx;
   logic        w_push;
   logic        w_drop;
   logic        w_clr_ovf;
   logic        w_rd_status;
   logic [31:0] w_status;

   // FIFO / transmitter side
   logic        w_full;
   logic        w_empty;
   logic [7:0]  w_rdata;
   logic        w_load;
   logic        w_bit_end;
   tx_state_t   r_state;
   logic [BW-1:0] r_baud;
   logic [2:0]  r_bitcnt;
   logic [7:0]  r_data;
   logic        r_tx;

   logic        w_unused;
   assign w_unused = ^{wb_sel_i[3:1], wb_dat_i[31:8], wb_adr_i[1:0]};

   assign wb_ack_o = r_ack;
   assign wb_dat_o = r_dat_o;
   assign uart_tx  = r_tx;

   // A new request is taken only when no ack is outstanding, which yields the
   // ack-every-other-cycle behaviour for back-to-back requests.
   assign w_req       = wb_cyc_i & wb_stb_i & ~r_ack;
   // Writes take effect in the ack cycle using the still-held bus values.
   assign w_wr        = r_ack & wb_cyc_i & wb_stb_i & wb_we_i;
   assign w_wr_tx     = w_wr & (wb_adr_i[2] == REG_TXDATA[2]) & wb_sel_i[0];
   assign w_push      = w_wr_tx & ~w_full;
   assign w_drop      = w_wr_tx & w_full;
   assign w_clr_ovf   = w_wr & (wb_adr_i[2] == REG_STATUS[2]) & wb_dat_i[STAT_OVF];
   assign w_rd_status = w_req & ~wb_we_i & (wb_adr_i[2] == REG_STATUS[2]);

   always_comb begin
      w_status             = '0;
      w_status[STAT_FULL]  = w_full;
      w_status[STAT_EMPTY] = w_empty;
      w_status[STAT_BUSY]  = (r_state != ST_IDLE);
      w_status[STAT_OVF]   = r_ovf;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_ack   <= 1'b0;
         r_dat_o <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_ack   <= w_req;
         r_dat_o <= w_rd_status ? w_status : '0;
         // A drop wins over a clear landing in the same cycle.
         if (w_drop)         r_ovf <= 1'b1;
         else if (w_clr_ovf) r_ovf <= 1'b0;
      end
   end

   wb_uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (wb_clk_i),
      .i_rst   (wb_rst_i),
      .i_push  (w_push),
      .i_wdata (wb_dat_i[7:0]),
      .i_pop   (w_load),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_rdata (w_rdata)
   );

   assign w_bit_end = (r_baud == BW'(DIV - 1));
   // Pop from IDLE, or at the end of STOP to chain frames with no idle gap.
   assign w_load    = ~w_empty & ((r_state == ST_IDLE) |
                                  ((r_state == ST_STOP) & w_bit_end));

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state  <= ST_IDLE;
         r_baud   <= '0;
         r_bitcnt <= '0;
         r_data   <= '0;
         r_tx     <= 1'b1;
      end else begin
         if (r_state != ST_IDLE) r_baud <= w_bit_end ? '0 : r_baud + BW'(1);
         // Line level is registered together with the state change, so each
         // state's bit appears for exactly DIV cycles.
         case (r_state)
            ST_IDLE: begin
               if (w_load) begin
                  r_state <= ST_START;
                  r_data  <= w_rdata;
                  r_baud  <= '0;
                  r_tx    <= 1'b0;
               end
            end
            ST_START: begin
               if (w_bit_end) begin
                  r_state  <= ST_DATA;
                  r_bitcnt <= '0;
                  r_tx     <= r_data[0];
               end
            end
            ST_DATA: begin
               if (w_bit_end) begin
                  if (r_bitcnt == 3'd7) begin
`ifdef WB_UART_TX_PARITY_EN
                     r_state <= ST_PARITY;
                     r_tx    <= ^r_data;
`else
                     r_state <= ST_STOP;
                     r_tx    <= 1'b1;
`endif
                  end else begin
                     r_bitcnt <= r_bitcnt + 3'd1;
                     r_tx     <= r_data[r_bitcnt + 3'd1];
                  end
               end
            end
`ifdef WB_UART_TX_PARITY_EN
            ST_PARITY: begin
               if (w_bit_end) begin
                  r_state <= ST_STOP;
                  r_tx    <= 1'b1;
               end
            end
`endif
            ST_STOP: begin
               if (w_bit_end) begin
                  if (w_load) begin
                     r_state <= ST_START;
                     r_data  <= w_rdata;
                     r_tx    <= 1'b0;
                  end else begin
                     r_state <= ST_IDLE;
                     r_tx    <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_wb_uart_tx
// Drives Wishbone transfers into wb_uart_tx (DIV=10) and compares the serial
// line cycle-by-cycle against a frame-level model: each accepted byte occupies
// the line from start = max(ack_cycle+2, previous_frame_end) for NBITS*DIV
// cycles, and the line is high elsewhere. STATUS reads are predicted from the
// same frame list. Define WB_UART_TX_PARITY_EN to check the 8E1 build.
// -----------------------------------------------------------------------------
module tb_wb_uart_tx;

   localparam int DIV   = 10;
   localparam int DEPTH = 16;
`ifdef WB_UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  adr = '0;
   logic [31:0] dati = '0;
   logic [31:0] dato;
   logic        we = 1'b0, stb = 1'b0, cyc = 1'b0;
   logic [3:0]  sel = '0;
   logic        ack;
   logic        tx;

   int checks = 0;
   int failures = 0;
   int cyc_n = 0;
   bit line_mem [0:65535];

   wb_uart_tx #(
      .CLK_FREQ_HZ (10000000),
      .BAUD        (1000000),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wb_adr_i (adr),
      .wb_dat_i (dati),
      .wb_dat_o (dato),
      .wb_we_i  (we),
      .wb_stb_i (stb),
      .wb_cyc_i (cyc),
      .wb_sel_i (sel),
      .wb_ack_o (ack),
      .uart_tx  (tx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;
   always @(negedge clk) line_mem[cyc_n % 65536] <= tx;

   initial begin
      #5ms;
      $display("FAIL watchdog expired at cycle %0d", cyc_n);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   int         m_push[$];
   int         m_start[$];
   logic [7:0] m_byte[$];
   bit         m_ovf;
   int         last_end;

   function automatic void model_reset();
      m_push.delete(); m_start.delete(); m_byte.delete();
      m_ovf = 1'b0;
      last_end = 0;
   endfunction

   // Bytes held in the FIFO during cycle t: pushed earlier, not yet popped
   // (a byte is popped in the cycle just before its frame starts).
   function automatic int m_count(int t);
      int n = 0;
      foreach (m_push[i]) if (m_push[i] < t && m_start[i] > t) n++;
      return n;
   endfunction

   function automatic bit m_busy(int t);
      foreach (m_start[i]) if (t >= m_start[i] && t < m_start[i] + FRAME) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_status(int t);
      logic [31:0] s = '0;
      s[0] = (m_count(t) == DEPTH);
      s[1] = (m_count(t) == 0);
      s[2] = m_busy(t);
      s[3] = m_ovf;
      return s;
   endfunction

   function automatic logic exp_line(int t);
      foreach (m_start[i]) begin
         if (t >= m_start[i] && t < m_start[i] + FRAME) begin
            int j = (t - m_start[i]) / DIV;
            logic [7:0] b = m_byte[i];
            if (j == 0) return 1'b0;
            if (j <= 8) return b[j-1];
            if (NBITS == 11 && j == 9) return ^b;
            return 1'b1;
         end
      end
      return 1'b1;
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc_n < c) begin @(posedge clk); #1; end
   endtask

   task automatic wb_xfer(input bit w, input logic [2:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output int t_ack);
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dati = d; sel = s;
      @(posedge clk); #1;
      chk("ack_rise", ack, 1);
      t_ack = cyc_n;
      rd = dato;
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      chk("ack_one_cycle", ack, 0);
      chk("dat_zero_no_ack", dato, 0);
   endtask

   task automatic write_tx(input logic [7:0] b, input logic [3:0] s);
      logic [31:0] rd;
      int t, st;
      wb_xfer(1'b1, {1'b0, 2'($urandom)}, {24'($urandom), b}, s, rd, t);
      if (s[0]) begin
         if (m_count(t) == DEPTH) m_ovf = 1'b1;
         else begin
            st = (t + 2 > last_end) ? t + 2 : last_end;
            m_push.push_back(t); m_start.push_back(st); m_byte.push_back(b);
            last_end = st + FRAME;
         end
      end
   endtask

   task automatic write_status(input logic [31:0] d);
      logic [31:0] rd;
      int t;
      wb_xfer(1'b1, {1'b1, 2'($urandom)}, d, 4'hF, rd, t);
      if (d[3]) m_ovf = 1'b0;
   endtask

   task automatic read_status(input string tag, output logic [31:0] rd);
      int t;
      wb_xfer(1'b0, {1'b1, 2'($urandom)}, $urandom, 4'($urandom), rd, t);
      // read data is captured in the request cycle, one before the ack
      chk(tag, rd, m_status(t - 1));
   endtask

   task automatic check_window(input string tag, input int from, input int to);
      logic [31:0] first_bad = '1;
      for (int c = to; c >= from; c--)
         if (line_mem[c % 65536] !== exp_line(c)) first_bad = c;
      chk(tag, first_bad, 32'hFFFF_FFFF);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] rd;
      int t0, t_ack, st;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx", tx, 1);
      chk("rst_ack", ack, 0);
      chk("rst_dat", dato, 0);
      rst = 1'b0;
      model_reset();
      read_status("rst_status", rd);
      chk("rst_status_const", rd, 32'h2);

      // single frame 0x55
      t0 = cyc_n;
      write_tx(8'h55, 4'hF);
      wait_until(t0 + 40);
      read_status("busy_mid_frame", rd);
      chk("busy_bit", rd[2], 1);
      wait_until(last_end + 10);
      check_window("frame_55", t0, cyc_n - 1);
      read_status("idle_after_55", rd);

      // back-to-back frames, no idle gap between them
      model_reset();
      t0 = cyc_n;
      write_tx(8'hA5, 4'hF);
      write_tx(8'h3C, 4'h1);
      wait_until(m_start[1] + 20);
      read_status("empty_after_last_pop", rd);
      chk("empty_busy_const", rd, 32'h6);
      wait_until(last_end + 10);
      check_window("frames_a5_3c", t0, cyc_n - 1);

      // overflow: one byte in flight, 16 buffered, 17th dropped
      model_reset();
      t0 = cyc_n;
      write_tx(8'($urandom), 4'hF);
      for (int i = 0; i < 16; i++) write_tx(8'($urandom), 4'hF);
      read_status("full_after_16", rd);
      chk("full_bit", rd[0], 1);
      write_tx(8'($urandom), 4'hF);
      read_status("ovf_after_17", rd);
      chk("ovf_bit", rd[3], 1);
      write_status(32'h8);
      read_status("ovf_cleared", rd);
      chk("ovf_clear_bit", rd[3], 0);
      wait_until(last_end + 10);
      check_window("overflow_drain", t0, cyc_n - 1);

      // sel[0]=0 write does not push; TXDATA reads return zero
      model_reset();
      t0 = cyc_n;
      write_tx(8'h00, 4'b0010);
      wb_xfer(1'b0, 3'b001, 32'h0, 4'hF, rd, t_ack);
      chk("txdata_read_zero", rd, 0);
      read_status("no_push_status", rd);
      chk("no_push_const", rd, 32'h2);
      wait_until(t0 + 60);
      check_window("no_push_line_high", t0, cyc_n - 1);

      // parity patterns (plain frames in the 8N1 build)
      model_reset();
      t0 = cyc_n;
      write_tx(8'h07, 4'hF);
      write_tx(8'h03, 4'hF);
      wait_until(last_end + 10);
      check_window("frames_07_03", t0, cyc_n - 1);

      // randomized bytes, byte lanes and gaps
      model_reset();
      t0 = cyc_n;
      for (int i = 0; i < 10; i++) begin
         logic [3:0] s = 4'($urandom);
         if ($urandom_range(0, 3) != 0) s[0] = 1'b1;
         write_tx(8'($urandom), s);
         if ($urandom_range(0, 1) == 1) read_status("rand_status", rd);
         repeat ($urandom_range(0, 150)) @(posedge clk);
         #1;
      end
      wait_until(last_end + 10);
      check_window("random_frames", t0, cyc_n - 1);

      // reset mid-DATA of 0xFF with a byte queued behind it
      model_reset();
      write_tx(8'hFF, 4'hF);
      write_tx(8'h00, 4'hF);
      st = m_start[0];
      wait_until(st + 4 * DIV + 3);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_data_tx", tx, 1);
      chk("rst_mid_data_ack", ack, 0);
      rst = 1'b0;
      model_reset();
      read_status("status_after_rst", rd);
      chk("status_after_rst_const", rd, 32'h2);
      t0 = cyc_n;
      wait_until(t0 + 2 * FRAME);
      check_window("no_frame_after_rst", t0, cyc_n - 1);

      // reset during START: line must return high at once
      write_tx(8'h00, 4'hF);
      wait_until(m_start[0] + 3);
      chk("start_bit_low", tx, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_start_tx", tx, 1);
      rst = 1'b0;
      model_reset();
      t0 = cyc_n;
      wait_until(t0 + FRAME + 20);
      check_window("no_frame_after_rst2", t0, cyc_n - 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
